// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bundle and default width for the ALU datapath.
package alu_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_ADD  = 3'd4;
   localparam logic [2:0] OP_SUB  = 3'd5;
   localparam logic [2:0] OP_SLT  = 3'd6;
   localparam logic [2:0] OP_SLTU = 3'd7;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational op/flag evaluator; shared by the pipelined and single-cycle ALUs.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output flags_t           flags
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   // Select the operation; carry/ovf only meaningful for ADD and SUB.
   always_comb begin
      result = '0;
      flags  = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_ADD: begin
            result      = sum[WIDTH-1:0];
            flags.carry = sum[WIDTH];
            flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result      = diff[WIDTH-1:0];
            // diff[WIDTH] is the borrow, so carry means A >= B unsigned
            flags.carry = ~diff[WIDTH];
            flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
         default: result = '0;
      endcase
      flags.zero = (result == '0);
      flags.neg  = result[WIDTH-1];
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU with valid/ready on both sides and a saturating handoff counter.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [CNT_W-1:0] ops_done
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;
   logic             s2_valid;
   flags_t           s2_flags;
   logic [WIDTH-1:0] core_result;
   flags_t           core_flags;
   logic             s2_load;
   logic             accept;
   logic             handoff;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .result (core_result),
      .flags  (core_flags)
   );

   assign s2_load  = !s2_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;
   assign accept   = in_valid && in_ready;
   assign handoff  = s2_valid && out_ready;

   // Stage 1: capture operands on accept; drain when S2 takes the beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: register the evaluated result; data only moves with a valid beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid   <= 1'b0;
         out_result <= '0;
         s2_flags   <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= core_result;
            s2_flags   <= core_flags;
         end
      end
   end

   // Count handoffs, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         ops_done <= '0;
      end else if (handoff && (ops_done != {CNT_W{1'b1}})) begin
         ops_done <= ops_done + 1'b1;
      end
   end

   assign out_valid = s2_valid;
   assign out_zero  = s2_flags.zero;
   assign out_neg   = s2_flags.neg;
   assign out_carry = s2_flags.carry;
   assign out_ovf   = s2_flags.ovf;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational AND unit.
- Accepts two WIDTH-bit operands plus an opcode through a valid/ready handshake.
- Computes one of eight logic/arithmetic operations over two register stages and returns the result with status flags through a second valid/ready handshake.
- Sits between the operand-fetch logic and writeback in the ALU datapath. Also keeps a saturating count of completed operations.

Parameters:
- WIDTH, 32, operand and result width in bits (legal range 4..64).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/opcode beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode (see Behaviour).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result this cycle.
- out_result  output  WIDTH  result.
- out_zero  output  1  result equals 0.
- out_neg  output  1  result MSB.
- out_carry  output  1  carry flag.
- out_ovf  output  1  signed-overflow flag.
- ops_done  output  CNT_W  count of results handed off; saturating.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR.
  - 4 ADD (A+B), 5 SUB (A-B).
  - 6 SLT: result 1 if A<B signed, else 0.
  - 7 SLTU: result 1 if A<B unsigned, else 0.
- Arithmetic: computed at WIDTH+1 bits; result is the low WIDTH bits.
- Carry flag:
  - ADD: bit WIDTH of the sum.
  - SUB: 1 when A>=B unsigned (no borrow).
  - All other ops: 0.
- Overflow flag:
  - ADD: operands have equal signs and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
  - All other ops: 0.
- Zero and negative flags are valid for every opcode.
- Stage 1 (S1): registers in_a, in_b, in_op and s1_valid when the beat is accepted.
- Stage 2 (S2): computes from the S1 registers and registers result, flags and s2_valid. The out_* ports are driven directly from S2 registers.
- Latency: with no backpressure, out_valid rises 2 cycles after in_valid&&in_ready is sampled. Throughput is 1 beat per cycle.
- Stage advance rules:
  - S2 loads when it is empty or out_ready=1.
  - S1 advances into S2 whenever S2 loads.
  - in_ready = !s1_valid || s2_loads. This is combinational from out_ready and is the only combinational input-to-output path.
- Stall: while out_valid=1 and out_ready=0, out_result and all flags hold stable. Both stages fill, then in_ready=0 and no beat is lost or duplicated.
- Simultaneous events:
  - Accept and handoff in the same cycle: both occur and pipeline occupancy is unchanged.
  - A beat in S1 with S2 draining moves forward in that same cycle.
- Counter: ops_done increments on every cycle with out_valid&&out_ready. It saturates at all-ones and does not wrap.
- Reset: when reset=1 at a rising edge, s1_valid, s2_valid, out_result, all flags and ops_done clear to 0. Any in-flight beats are discarded, including mid-stall. The first accept is possible in the cycle after reset deasserts, and in_ready=1 then.
- No X propagation: data registers load only on a valid advance.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND..OP_SLTU, 3 bits);
  - a flags struct {zero, neg, carry, ovf};
  - default WIDTH.
- One natural sub-module: alu_core. It is a purely combinational WIDTH-parametrised op/flag evaluator between S1 and S2 and is also reusable by the single-cycle unit.
- Handshake and counter logic stay in alu_pipe.

Test Plan:
- Reset, then WIDTH=32, out_ready=1; send AND 2,3 / 1,3 / 6,2 / 5,9 / 10,10 / 10,6 back-to-back. Required results 2,1,2,1,10,2, each 2 cycles after its beat, one per cycle. ops_done ends at 6.
- ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry=1, ovf=0. ADD 0x7FFFFFFF+1 -> 0x80000000, neg=1, ovf=1, carry=0.
- SUB 3-5 -> 0xFFFFFFFE, carry=0, neg=1. SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1, carry=1. SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
- Backpressure: hold out_ready=0 while streaming 4 beats. Required: in_ready drops after 2 accepts and output stays stable. Release out_ready: all beats emerge in order with no duplicates, and ops_done=4.
- Reset asserted for 1 cycle with both stages full -> next cycle out_valid=0, in_ready=1, ops_done=0. A new beat then emerges after 2 cycles.
- CNT_W=4, WIDTH=8: perform 20 handoffs -> ops_done saturates at 15. OR 0xA5,0x5A -> 0xFF with neg=1.
